// File: rtl/aes_job_arbiter.sv
// aes_job_arbiter: two-requester front end for a single AES core.
// Picks one pending job, latches its mode/key/text onto the core buses,
// starts the core and waits for completion with a bounded timer. It then
// returns the result, or an error on timeout, to the requester that owns the job.
//
// Handshake: a requester holds reqN high with its job inputs stable until
// gntN pulses. The inputs are captured on the edge that raises gntN, so they
// may change freely afterwards. core_start is a one-cycle strobe. The core
// answers with a one-cycle core_done, and core_text_out is valid in that cycle.
// rsp_validN is a one-cycle strobe, and rsp_err qualifies it. rsp_data holds
// its value until the next response.
module aes_job_arbiter #(
  parameter logic [15:0] TIMEOUT = 16'd1024
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         req0,
  input  logic         req1,
  input  logic [2:0]   mode0,
  input  logic [2:0]   mode1,
  input  logic [255:0] key0,
  input  logic [255:0] key1,
  input  logic [127:0] text0,
  input  logic [127:0] text1,
  output logic         gnt0,
  output logic         gnt1,
  output logic         core_start,
  output logic [2:0]   core_mode,
  output logic [255:0] core_key,
  output logic [127:0] core_text,
  input  logic         core_done,
  input  logic [127:0] core_text_out,
  output logic         rsp_valid0,
  output logic         rsp_valid1,
  output logic [127:0] rsp_data,
  output logic         rsp_err,
  output logic         busy,
  output logic [1:0]   dbg_state_o
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_e;

  state_e         state_q, state_d;
  logic           rr_q, rr_d;          // 1 = requester 1 wins the next tie
  logic           owner_q, owner_d;    // requester that owns the job in flight
  logic [15:0]    timer_q, timer_d;
  logic [1:0]     gnt_q, gnt_d;
  logic           start_q, start_d;
  logic [2:0]     mode_q, mode_d;
  logic [255:0]   key_q, key_d;
  logic [127:0]   text_q, text_d;
  logic [1:0]     rsp_valid_q, rsp_valid_d;
  logic [127:0]   rsp_data_q, rsp_data_d;
  logic           rsp_err_q, rsp_err_d;
  logic           pick;

  // State register and all registered outputs; reset clears everything.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      rr_q        <= 1'b0;
      owner_q     <= 1'b0;
      timer_q     <= 16'd0;
      gnt_q       <= 2'b00;
      start_q     <= 1'b0;
      mode_q      <= 3'd0;
      key_q       <= 256'd0;
      text_q      <= 128'd0;
      rsp_valid_q <= 2'b00;
      rsp_data_q  <= 128'd0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      rr_q        <= rr_d;
      owner_q     <= owner_d;
      timer_q     <= timer_d;
      gnt_q       <= gnt_d;
      start_q     <= start_d;
      mode_q      <= mode_d;
      key_q       <= key_d;
      text_q      <= text_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  // Next-state logic: arbitration, core start, bounded wait and response.
  always_comb begin
    state_d     = state_q;
    rr_d        = rr_q;
    owner_d     = owner_q;
    timer_d     = timer_q;
    gnt_d       = 2'b00;
    start_d     = 1'b0;
    mode_d      = mode_q;
    key_d       = key_q;
    text_d      = text_q;
    rsp_valid_d = 2'b00;
    rsp_data_d  = rsp_data_q;
    rsp_err_d   = rsp_err_q;
    pick        = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (req0 || req1) begin
          // A lone requester always wins; a tie goes to the round-robin favourite.
          pick        = (req0 && req1) ? rr_q : req1;
          owner_d     = pick;
          gnt_d[pick] = 1'b1;
          mode_d      = pick ? mode1 : mode0;
          key_d       = pick ? key1  : key0;
          text_d      = pick ? text1 : text0;
          state_d     = S_START;
        end
      end
      S_START: begin
        start_d = 1'b1;
        timer_d = 16'd0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (timer_q != TIMEOUT) begin
          timer_d = timer_q + 16'd1;
        end
        // A completion on the last allowed cycle still counts as success.
        if (core_done) begin
          rsp_data_d           = core_text_out;
          rsp_err_d            = 1'b0;
          rsp_valid_d[owner_q] = 1'b1;
          state_d              = S_RESP;
        end else if (timer_q == TIMEOUT - 16'd1) begin
          rsp_data_d           = 128'd0;
          rsp_err_d            = 1'b1;
          rsp_valid_d[owner_q] = 1'b1;
          state_d              = S_RESP;
        end
      end
      S_RESP: begin
        rr_d    = ~owner_q;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign gnt0        = gnt_q[0];
  assign gnt1        = gnt_q[1];
  assign core_start  = start_q;
  assign core_mode   = mode_q;
  assign core_key    = key_q;
  assign core_text   = text_q;
  assign rsp_valid0  = rsp_valid_q[0];
  assign rsp_valid1  = rsp_valid_q[1];
  assign rsp_data    = rsp_data_q;
  assign rsp_err     = rsp_err_q;
  assign busy        = (state_q != S_IDLE);
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_aes_job_arbiter.sv
// Bench for aes_job_arbiter. It uses a job-level reference model. Each job
// is described by its grant time and a planned core latency. From those two
// values the model derives which cycle carries the grant, the core start and
// the response, and what the response holds.
module tb_aes_job_arbiter;

  localparam int TMO = 8;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset_n;

  logic         req [2];
  logic [2:0]   mode [2];
  logic [255:0] key [2];
  logic [127:0] text [2];
  logic         core_done;
  logic [127:0] core_text_out;
  logic         gnt0, gnt1, core_start, rsp_valid0, rsp_valid1, rsp_err, busy;
  logic [2:0]   core_mode;
  logic [255:0] core_key;
  logic [127:0] core_text, rsp_data;
  logic [1:0]   dbg_state;

  aes_job_arbiter #(.TIMEOUT(16'd8)) dut (
    .clk(clk), .reset_n(reset_n),
    .req0(req[0]), .req1(req[1]),
    .mode0(mode[0]), .mode1(mode[1]),
    .key0(key[0]), .key1(key[1]),
    .text0(text[0]), .text1(text[1]),
    .gnt0(gnt0), .gnt1(gnt1),
    .core_start(core_start), .core_mode(core_mode),
    .core_key(core_key), .core_text(core_text),
    .core_done(core_done), .core_text_out(core_text_out),
    .rsp_valid0(rsp_valid0), .rsp_valid1(rsp_valid1),
    .rsp_data(rsp_data), .rsp_err(rsp_err), .busy(busy),
    .dbg_state_o(dbg_state)
  );

  // ---------------- scoreboard / reference model ----------------
  int checks, errors;
  int to_seen;
  bit dut_grants [$];

  bit           m_active, m_owner, m_rr, m_rsp_err;
  int           m_age, m_lat, m_resp_age;
  logic [2:0]   m_mode;
  logic [255:0] m_key;
  logic [127:0] m_text, m_done_text, m_rsp_data;

  int force_lat, drop_pct, stray_pct;
  int req_pct [2];

  task automatic check_eq(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  function automatic void model_reset();
    m_active = 0; m_owner = 0; m_rr = 0; m_rsp_err = 0;
    m_age = 0; m_lat = 0; m_resp_age = 0;
    m_mode = '0; m_key = '0; m_text = '0; m_done_text = '0; m_rsp_data = '0;
  endfunction

  // Advance the model across one rising edge using the inputs of the cycle just ended.
  // A job's age is 0 in its grant cycle. The core starts at age 1, and
  // core_done is driven at age 1+lat. The response comes at age lat+2, or at
  // TMO+1 when the core never answers in time.
  function automatic void model_edge();
    if (m_active) begin
      if (m_lat < TMO && m_age == m_lat + 1) m_done_text = core_text_out;
      m_age++;
      if (m_age == m_resp_age) begin
        m_rsp_err  = (m_lat >= TMO);
        m_rsp_data = m_rsp_err ? 128'd0 : m_done_text;
        m_rr       = ~m_owner;
      end else if (m_age == m_resp_age + 1) begin
        m_active = 0;
      end
    end else if (req[0] || req[1]) begin
      m_owner    = (req[0] && req[1]) ? m_rr : req[1];
      m_mode     = mode[m_owner];
      m_key      = key[m_owner];
      m_text     = text[m_owner];
      m_active   = 1;
      m_age      = 0;
      m_lat      = (force_lat >= 0) ? force_lat : int'($urandom_range(0, TMO + 3));
      m_resp_age = (m_lat < TMO) ? m_lat + 2 : TMO + 1;
    end
  endfunction

  function automatic logic [6:0] exp_ctrl();
    bit g, r;
    g = m_active && m_age == 0;
    r = m_active && m_age == m_resp_age;
    return {g && !m_owner, g && m_owner, m_active && m_age == 1, m_active,
            r && !m_owner, r && m_owner, m_rsp_err};
  endfunction

  task automatic check_outputs();
    check_eq("ctrl{gnt0,gnt1,start,busy,rv0,rv1,err}",
             {gnt0, gnt1, core_start, busy, rsp_valid0, rsp_valid1, rsp_err}, exp_ctrl());
    check_eq("rsp_data", rsp_data, m_rsp_data);
    check_eq("core_mode", core_mode, m_mode);
    check_eq("core_key", core_key, m_key);
    check_eq("core_text", core_text, m_text);
    if (gnt0) dut_grants.push_back(1'b0);
    if (gnt1) dut_grants.push_back(1'b1);
    if (rsp_valid1 && rsp_err && rsp_data == 128'd0) to_seen++;
  endtask

  // ---------------- driver tasks ----------------
  task automatic new_job(input int i);
    mode[i] = 3'($urandom_range(0, 7));
    key[i]  = {rnd128(), rnd128()};
    text[i] = rnd128();
  endtask

  task automatic drive_inputs();
    for (int i = 0; i < 2; i++) begin
      if (m_active && m_age == 0 && m_owner == i[0]) begin
        req[i] = 1'b0;
        new_job(i);                 // inputs change right after the grant
      end else if (!req[i]) begin
        new_job(i);
        if ($urandom_range(0, 99) < req_pct[i]) req[i] = 1'b1;
      end else if ($urandom_range(0, 99) < drop_pct) begin
        req[i] = 1'b0;              // withdrawn before grant
      end
    end
    core_text_out = rnd128();
    core_done = (m_active && m_lat < TMO && m_age == m_lat + 1) ||
                ((!m_active || m_age == 0 || m_age >= m_resp_age) &&
                 ($urandom_range(0, 99) < stray_pct));
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check_outputs();
    drive_inputs();
  endtask

  task automatic do_reset(input int cycles);
    reset_n = 1'b0;
    req[0] = 1'b0; req[1] = 1'b0; core_done = 1'b0;
    model_reset();
    #1;
    check_outputs();
    repeat (cycles) begin
      @(posedge clk);
      #1;
      check_outputs();
    end
    reset_n = 1'b1;
  endtask

  task automatic drain();
    req_pct[0] = 0; req_pct[1] = 0; drop_pct = 0; stray_pct = 0;
    req[0] = 1'b0; req[1] = 1'b0;
    for (int b = 0; b < 40 && m_active; b++) step();
    step();
    check_eq("drain_idle", busy, 1'b0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    checks = 0; errors = 0; to_seen = 0;
    reset_n = 1'b1;
    for (int i = 0; i < 2; i++) begin
      req[i] = 1'b0; mode[i] = '0; key[i] = '0; text[i] = '0;
    end
    core_done = 1'b0; core_text_out = '0;
    force_lat = -1; drop_pct = 0; stray_pct = 0;
    req_pct[0] = 0; req_pct[1] = 0;
    model_reset();
    #2;
    do_reset(3);

    // Contention: both requesters always pending; grants must alternate 0,1,0,1.
    dut_grants.delete();
    req_pct[0] = 100; req_pct[1] = 100; force_lat = 3;
    for (int b = 0; b < 200 && dut_grants.size() < 4; b++) step();
    check_eq("contention_grant_count", 32'(dut_grants.size() >= 4), 32'd1);
    for (int i = 0; i < 4; i++)
      if (i < dut_grants.size()) check_eq("contention_order", dut_grants[i], i % 2);
    drain();

    // Timeout on requester 1: the core never answers.
    to_seen = 0;
    req_pct[1] = 100; force_lat = 1000;
    repeat (14) step();
    drain();
    check_eq("timeout_response_seen", 32'(to_seen > 0), 32'd1);

    // core_done lands on the timeout cycle: success must win.
    req_pct[0] = 100; force_lat = TMO - 1;
    repeat (14) step();
    drain();

    // Reset while waiting on the core, then a normal job afterwards.
    req_pct[0] = 100; force_lat = 1000;
    for (int b = 0; b < 50 && !(m_active && m_age == 4); b++) step();
    check_eq("reached_wait", dbg_state, 2'd2);
    do_reset(2);
    req_pct[0] = 100; force_lat = 2; stray_pct = 30;
    repeat (12) step();
    drain();

    // Randomized traffic with stray core_done pulses and withdrawn requests.
    force_lat = -1; req_pct[0] = 30; req_pct[1] = 30; drop_pct = 3; stray_pct = 20;
    repeat (3000) step();
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/aes_job_arbiter.md
AES_JOB_ARBITER -- requirements
Module: aes_job_arbiter

Interface
REQ-001 Parameter TIMEOUT, default 16'd1024: number of WAIT cycles allowed for core_done before the job is aborted.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 reset_n  input  1  reset, asynchronous, active-low.
REQ-004 req0, req1  input  1 each  job request from requester 0/1; held high until the matching gnt pulse.
REQ-005 mode0, mode1  input  3 each  AES mode for the requester's job.
REQ-006 key0, key1  input  256 each  key for the requester's job.
REQ-007 text0, text1  input  128 each  input block for the requester's job.
REQ-008 gnt0, gnt1  output  1 each  one-cycle pulse; job inputs were latched on this edge.
REQ-009 core_start  output  1  one-cycle start pulse to the AES core.
REQ-010 core_mode  output  3  latched job mode driven to the core.
REQ-011 core_key  output  256  latched job key driven to the core.
REQ-012 core_text  output  128  latched job text driven to the core.
REQ-013 core_done  input  1  core completion strobe.
REQ-014 core_text_out  input  128  core result; valid when core_done=1.
REQ-015 rsp_valid0, rsp_valid1  output  1 each  one-cycle response strobe to requester 0/1.
REQ-016 rsp_data  output  128  result; held stable from the rsp_valid edge until the next response.
REQ-017 rsp_err  output  1  qualifies rsp_valid: 1 means timeout abort.
REQ-018 busy  output  1  high in every state except IDLE.

Function
REQ-019 FSM states: IDLE, START, WAIT, RESP. All outputs are registered or decoded from registered state.
REQ-020 IDLE, only req0 high: at the next edge the block latches mode0/key0/text0, pulses gnt0, sets owner=0 and enters START. The req1-only case mirrors this.
REQ-021 IDLE, req0 and req1 both high: grant goes to the requester not served last (rr_ptr). rr_ptr resets to favour requester 0.
REQ-022 START: core_start=1 for exactly one cycle. The timer clears to 0 and the FSM enters WAIT.
REQ-023 WAIT: the timer increments by 1 per cycle, saturating at TIMEOUT.
REQ-024 WAIT, core_done=1: capture core_text_out into rsp_data, set rsp_err=0, enter RESP.
REQ-025 WAIT, timer==TIMEOUT-1 and core_done=0: set rsp_data=0, set rsp_err=1, enter RESP.
REQ-026 If core_done and timeout occur in the same cycle, core_done wins.
REQ-027 RESP: rsp_valid<owner>=1 for one cycle. rr_ptr is set to favour the other requester, and the FSM returns to IDLE.
REQ-028 Back-to-back jobs: a request seen in IDLE the cycle after RESP is granted normally. Minimum job period is 4 cycles plus core latency.
REQ-029 core_done in IDLE, START or RESP is ignored with no state change.
REQ-030 Requester inputs may change after gnt without affecting the job in flight. core_mode/key/text stay stable from START until the next grant.
REQ-031 A req that drops before its gnt produces no job and no response.
REQ-032 At most one gnt, one rsp_valid and one core_start pulse per job. gnt0 and gnt1 are never high together; rsp_valid0 and rsp_valid1 are never high together.

Reset
REQ-033 While reset_n=0: state=IDLE, rr_ptr favours requester 0, timer=0, owner=0.
REQ-034 While reset_n=0, every output is 0, including the core_* buses, rsp_data, rsp_err and busy.
REQ-035 Reset asserted mid-job aborts the job immediately with no response. After release, the FSM starts in IDLE.

Verification
REQ-036 Single job: req0, mode0=0, key0=0, text0=128'h1 -> gnt0 one edge later, core_start the edge after. core_done with core_text_out=128'hA5 -> rsp_valid0=1, rsp_data=128'hA5, rsp_err=0.
REQ-037 Contention: req0 and req1 held high together from reset -> grant order 0, 1, 0, 1. Each rsp_valid matches its grant.
REQ-038 Timeout: TIMEOUT=8, core_done never asserted -> rsp_valid1=1 with rsp_err=1 and rsp_data=0, exactly 8 cycles after entering WAIT. busy then falls.
REQ-039 Collision: core_done on the timeout cycle -> rsp_err=0 and rsp_data=core_text_out.
REQ-040 Stability and stray done: change key0 after gnt0 -> core_key unchanged. core_done pulsed in IDLE -> no rsp_valid.
REQ-041 Reset in WAIT -> all outputs 0 and no rsp_valid. A new req0 after release is served normally.
